// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter and fetches instruction words into ir
// over a req/ack handshake with bounded wait and a sticky timeout error.
module fetch_unit #(
  parameter int                    BUS_WIDTH  = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_read,
  input  logic                  pc_inc,
  input  logic                  jump,
  input  logic                  z_flag,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  output logic [BUS_WIDTH-1:0]  ir,
  output logic                  ir_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          imem_read_d;
  logic          start;

  assign start = imem_read & ~imem_read_d;
  assign busy  = mem_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      imem_read_d <= 1'b0;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_valid    <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      imem_read_d <= imem_read;

      // PC updates run every cycle; a fetch already latched mem_addr so it is unaffected.
      if (jump && !z_flag) pc <= jump_addr;
      else if (pc_inc)     pc <= pc + ADDR_WIDTH'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            ir_valid <= 1'b0;
            cnt      <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven PC update vectors plus hand-written
// fetch handshake, timeout, edge-detect and reset-abort sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read, pc_inc, jump, z_flag, mem_ack;
  logic [7:0]  jump_addr;
  logic [15:0] mem_rdata;
  logic        mem_req, ir_valid, busy, fetch_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.BUS_WIDTH(16), .ADDR_WIDTH(8), .RESET_PC(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .imem_read(imem_read), .pc_inc(pc_inc), .jump(jump),
    .z_flag(z_flag), .jump_addr(jump_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid), .busy(busy),
    .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, inc, jmp, z;
    logic [7:0] addr;
    logic [7:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc"}, 32'(pc), 32'h00);
    chk({tag, " ir"}, 32'(ir), 32'h0);
    chk({tag, " ir_valid"}, 32'(ir_valid), 0);
    chk({tag, " mem_req"}, 32'(mem_req), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " fetch_err"}, 32'(fetch_err), 0);
  endtask

  initial begin
    int req_rises, valid_rises, k;
    logic prev_req, prev_valid;

    reset = 1'b1; imem_read = 0; pc_inc = 0; jump = 0; z_flag = 0;
    jump_addr = 8'h00; mem_ack = 0; mem_rdata = 16'h0;
    step(); step();
    chk_reset_state("reset");
    reset = 1'b0;

    // 1: single fetch, ack on the third WAIT cycle
    imem_read = 1; step(); imem_read = 0;
    chk("t1 req", 32'(mem_req), 1);
    chk("t1 busy", 32'(busy), 1);
    chk("t1 addr", 32'(mem_addr), 32'h00);
    chk("t1 ir_valid low", 32'(ir_valid), 0);
    step(); step();
    chk("t1 req held", 32'(mem_req), 1);
    chk("t1 addr held", 32'(mem_addr), 32'h00);
    mem_ack = 1; mem_rdata = 16'h1A2B; step(); mem_ack = 0;
    chk("t1 ir", 32'(ir), 32'h1A2B);
    chk("t1 ir_valid", 32'(ir_valid), 1);
    chk("t1 busy drop", 32'(busy), 0);
    chk("t1 req drop", 32'(mem_req), 0);

    // 2: PC update table
    vecs[0] = '{rst:0, inc:0, jmp:1, z:0, addr:8'hFE, exp_pc:8'hFE};
    vecs[1] = '{rst:0, inc:1, jmp:0, z:0, addr:8'h00, exp_pc:8'hFF};
    vecs[2] = '{rst:0, inc:1, jmp:0, z:0, addr:8'h00, exp_pc:8'h00};
    vecs[3] = '{rst:0, inc:1, jmp:1, z:0, addr:8'h40, exp_pc:8'h40};
    vecs[4] = '{rst:0, inc:0, jmp:1, z:1, addr:8'h80, exp_pc:8'h40};
    vecs[5] = '{rst:0, inc:1, jmp:1, z:1, addr:8'h80, exp_pc:8'h41};
    vecs[6] = '{rst:0, inc:0, jmp:0, z:0, addr:8'h99, exp_pc:8'h41};
    vecs[7] = '{rst:1, inc:1, jmp:1, z:0, addr:8'h77, exp_pc:8'h00};
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst; pc_inc = vecs[i].inc; jump = vecs[i].jmp;
      z_flag = vecs[i].z; jump_addr = vecs[i].addr;
      step();
      chk($sformatf("pc vec %0d", i), 32'(pc), 32'(vecs[i].exp_pc));
    end
    reset = 0; pc_inc = 0; jump = 0; z_flag = 0;

    // 3: imem_read held high, immediate acks
    req_rises = 0; valid_rises = 0; prev_req = mem_req; prev_valid = ir_valid;
    imem_read = 1; mem_rdata = 16'h3C3C;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) imem_read = 0;
      step();
      if (mem_req && !prev_req) req_rises++;
      if (ir_valid && !prev_valid) valid_rises++;
      prev_req = mem_req; prev_valid = ir_valid;
      mem_ack = mem_req;
    end
    mem_ack = 0;
    chk("t3 req count", 32'(req_rises), 1);
    chk("t3 ir updates", 32'(valid_rises), 1);
    chk("t3 ir", 32'(ir), 32'h3C3C);

    // 4: timeout, then a successful fetch
    jump = 1; jump_addr = 8'h22; step(); jump = 0;
    imem_read = 1; step(); imem_read = 0;
    chk("t4 req", 32'(mem_req), 1);
    k = 0;
    while (mem_req && k < 40) begin step(); k++; end
    chk("t4 timeout cycles", 32'(k), 16);
    chk("t4 fetch_err", 32'(fetch_err), 1);
    chk("t4 ir kept", 32'(ir), 32'h3C3C);
    chk("t4 ir_valid", 32'(ir_valid), 0);
    step(); step();
    imem_read = 1; step(); imem_read = 0;
    chk("t4 refetch addr", 32'(mem_addr), 32'h22);
    mem_ack = 1; mem_rdata = 16'h5A5A; step(); mem_ack = 0;
    chk("t4 refetch ir", 32'(ir), 32'h5A5A);
    chk("t4 refetch valid", 32'(ir_valid), 1);
    chk("t4 err sticky", 32'(fetch_err), 1);

    // 5: start with pc_inc on same edge, pc_inc and second edge during WAIT
    imem_read = 1; pc_inc = 1; step(); imem_read = 0;
    chk("t5 addr old pc", 32'(mem_addr), 32'h22);
    chk("t5 pc inc", 32'(pc), 32'h23);
    step(); pc_inc = 0;
    chk("t5 pc wait", 32'(pc), 32'h24);
    chk("t5 addr frozen", 32'(mem_addr), 32'h22);
    imem_read = 1; step(); imem_read = 0;
    chk("t5 req still", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 16'h7777; step(); mem_ack = 0;
    chk("t5 ir", 32'(ir), 32'h7777);
    step(); step();
    chk("t5 no queued fetch", 32'(mem_req), 0);

    // 6: reset mid-WAIT, ack the following cycle
    imem_read = 1; step(); imem_read = 0;
    chk("t6 req", 32'(mem_req), 1);
    reset = 1; step(); reset = 0;
    mem_ack = 1; mem_rdata = 16'hDEAD; step(); mem_ack = 0;
    chk_reset_state("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
